// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
//   Bundles the two handshakes of the fetch front-end:
//     memory side : mem_req/mem_addr out, mem_ack/mem_rdata back
//     core side   : instr_valid/instr/instr_pc/count out, instr_ready back,
//                   plus the redirect/redirect_pc flush request from the core
//   master : the fetch queue itself
//   slave  : the environment (instruction memory + core)
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                     mem_req;
    logic [31:0]              mem_addr;
    logic                     mem_ack;
    logic [31:0]              mem_rdata;
    logic                     instr_valid;
    logic [31:0]              instr;
    logic [31:0]              instr_pc;
    logic                     instr_ready;
    logic                     redirect;
    logic [31:0]              redirect_pc;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc, count,
        input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc, count,
        output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch front-end for the single-cycle core. Issues sequential
//   word fetches to a variable-latency instruction memory (one request
//   outstanding at most), buffers returned words with their PCs in a
//   DEPTH-entry FIFO and presents the head to the core over valid/ready.
//   A redirect flushes the FIFO on the same edge and restarts fetch at
//   redirect_pc; a response that was already in flight is dropped.
//
//   Ports:
//     clock : system clock, all state updates on the rising edge
//     reset : synchronous, active-high
//     bus   : fetch_queue_if.master (memory request/ack, core valid/ready,
//             redirect, occupancy count)
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input logic           clock,
    input logic           reset,
    fetch_queue_if.master bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,     // no request on the bus
        REQ,      // live request at fetchPc
        DISCARD   // request made before a redirect; its data will be dropped
    } fetchStateT;

    fetchStateT    state, stateNext;
    logic [31:0]   fetchPc, fetchPcNext;
    logic [31:0]   discardAddr, discardAddrNext;
    logic [CW-1:0] count, countNext;
    logic [PW-1:0] wrPtr, rdPtr;
    logic          push, pop;

    logic [31:0]   pcMem   [DEPTH];
    logic [31:0]   dataMem [DEPTH];

    // ------------------------------------------------------------------
    // Next-state / queue-control logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first, so no branch can leave
        // one unassigned and infer a latch.
        stateNext       = state;
        fetchPcNext     = fetchPc;
        discardAddrNext = discardAddr;

        pop  = (count != '0) && bus.instr_ready;
        // Only a live request's data is queued; a same-cycle redirect kills it.
        push = (state == REQ) && bus.mem_ack && !bus.redirect;

        if (bus.redirect) begin
            countNext = '0;
        end else begin
            countNext = count + CW'(push) - CW'(pop);
        end

        case (state)
            IDLE: begin
                if (bus.redirect) begin
                    fetchPcNext = bus.redirect_pc;
                end else if (countNext < DepthC) begin
                    stateNext = REQ;
                end
            end

            REQ: begin
                if (bus.mem_ack) begin
                    if (bus.redirect) begin
                        // Request completed this cycle, so the new target can
                        // be issued straight away without a discard phase.
                        fetchPcNext = bus.redirect_pc;
                        stateNext   = REQ;
                    end else begin
                        fetchPcNext = fetchPc + PC_STEP;
                        stateNext   = (countNext < DepthC) ? REQ : IDLE;
                    end
                end else if (bus.redirect) begin
                    // The memory still owns the old request: keep presenting
                    // its address until it is acked, then throw the data away.
                    fetchPcNext     = bus.redirect_pc;
                    discardAddrNext = fetchPc;
                    stateNext       = DISCARD;
                end
            end

            DISCARD: begin
                if (bus.redirect) begin
                    fetchPcNext = bus.redirect_pc;
                end
                if (bus.mem_ack) begin
                    stateNext = (countNext < DepthC) ? REQ : IDLE;
                end
            end

            default: stateNext = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: registered state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (reset) begin
            state       <= IDLE;
            fetchPc     <= RESET_PC;
            discardAddr <= RESET_PC;
            count       <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
        end else begin
            state       <= stateNext;
            fetchPc     <= fetchPcNext;
            discardAddr <= discardAddrNext;
            count       <= countNext;
            if (bus.redirect) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + PW'(1);
                if (pop)  rdPtr <= rdPtr + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------
    // NOTE: the storage array is deliberately not reset; count/instr_valid
    // decide whether an entry is meaningful, so stale contents are harmless.
    always_ff @(posedge clock) begin
        if (push) begin
            pcMem[wrPtr]   <= fetchPc;
            dataMem[wrPtr] <= bus.mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all derived from registered state)
    // ------------------------------------------------------------------
    assign bus.mem_req     = (state == REQ) || (state == DISCARD);
    assign bus.mem_addr    = (state == DISCARD) ? discardAddr : fetchPc;
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = dataMem[rdPtr];
    assign bus.instr_pc    = pcMem[rdPtr];
    assign bus.count       = count;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//   Directed scenarios for fetch_queue: reset state, zero-wait streaming,
//   queue fill / stall, redirect during a wait, redirect coinciding with an
//   ack, reset with a pending request, and fetch PC wrap at 2^32.
//   Memory data is a fixed function of the address so expected words follow
//   directly from expected PCs.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    logic clock;
    logic reset;

    int assertCount;
    int failCount;

    fetch_queue_if #(.DEPTH(4)) bus ();

    fetch_queue #(
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] wordFor(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory returns its word in the same cycle as the ack.
    assign bus.mem_rdata = wordFor(bus.mem_addr);

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset           = 1'b1;
        bus.mem_ack     = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        step();
        step();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        assertCount++;
        if (bus.mem_req !== 1'b0) begin
            failCount++;
            $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req);
        end
        assertCount++;
        if (bus.instr_valid !== 1'b0) begin
            failCount++;
            $display("FAIL reset_instr_valid: got %b expected 0", bus.instr_valid);
        end
        assertCount++;
        if (bus.count !== 3'd0) begin
            failCount++;
            $display("FAIL reset_count: got %0d expected 0", bus.count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stream();
        doReset();
        bus.mem_ack     = 1'b1;
        bus.instr_ready = 1'b1;
        step();
        assertCount++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
            failCount++;
            $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=00000000",
                     bus.mem_req, bus.mem_addr);
        end
        assertCount++;
        if (bus.instr_valid !== 1'b0) begin
            failCount++;
            $display("FAIL stream_first_valid: got %b expected 0", bus.instr_valid);
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] expPc;
            expPc = 32'(i * 4);
            step();
            assertCount++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== expPc ||
                bus.instr !== wordFor(expPc)) begin
                failCount++;
                $display("FAIL stream_head[%0d]: got v=%b pc=%h w=%h expected v=1 pc=%h w=%h",
                         i, bus.instr_valid, bus.instr_pc, bus.instr, expPc, wordFor(expPc));
            end
            assertCount++;
            if (bus.count !== 3'd1) begin
                failCount++;
                $display("FAIL stream_count[%0d]: got %0d expected 1", i, bus.count);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_fill();
        doReset();
        bus.mem_ack     = 1'b1;
        bus.instr_ready = 1'b0;
        step();             // request for 0 issued
        step();             // 0 pushed
        step();             // 4 pushed
        step();             // 8 pushed
        step();             // 12 pushed, queue full
        assertCount++;
        if (bus.count !== 3'd4 || bus.mem_req !== 1'b0) begin
            failCount++;
            $display("FAIL fill_full: got count=%0d req=%b expected count=4 req=0",
                     bus.count, bus.mem_req);
        end
        assertCount++;
        if (bus.instr_pc !== 32'h0 || bus.instr !== wordFor(32'h0)) begin
            failCount++;
            $display("FAIL fill_head: got pc=%h w=%h expected pc=00000000 w=%h",
                     bus.instr_pc, bus.instr, wordFor(32'h0));
        end
        step();             // still full, must stay idle
        assertCount++;
        if (bus.mem_req !== 1'b0 || bus.count !== 3'd4) begin
            failCount++;
            $display("FAIL fill_hold: got req=%b count=%0d expected req=0 count=4",
                     bus.mem_req, bus.count);
        end
        bus.instr_ready = 1'b1;
        step();             // one pop frees a slot
        bus.instr_ready = 1'b0;
        assertCount++;
        if (bus.count !== 3'd3) begin
            failCount++;
            $display("FAIL fill_pop_count: got %0d expected 3", bus.count);
        end
        assertCount++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10) begin
            failCount++;
            $display("FAIL fill_resume_req: got req=%b addr=%h expected req=1 addr=00000010",
                     bus.mem_req, bus.mem_addr);
        end
        assertCount++;
        if (bus.instr_pc !== 32'h4) begin
            failCount++;
            $display("FAIL fill_pop_head: got %h expected 00000004", bus.instr_pc);
        end
        step();             // word 16 pushed, full again
        assertCount++;
        if (bus.count !== 3'd4 || bus.mem_req !== 1'b0) begin
            failCount++;
            $display("FAIL fill_refull: got count=%0d req=%b expected count=4 req=0",
                     bus.count, bus.mem_req);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_redirect_wait();
        doReset();
        bus.mem_ack     = 1'b0;
        bus.instr_ready = 1'b1;
        step();             // request for 0 issued, memory waits
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        step();             // redirect during the wait
        bus.redirect    = 1'b0;
        assertCount++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
            failCount++;
            $display("FAIL rdw_hold_old: got req=%b addr=%h expected req=1 addr=00000000",
                     bus.mem_req, bus.mem_addr);
        end
        bus.mem_ack = 1'b1;
        step();             // stale word acked and dropped
        bus.mem_ack = 1'b0;
        assertCount++;
        if (bus.instr_valid !== 1'b0 || bus.count !== 3'd0) begin
            failCount++;
            $display("FAIL rdw_dropped: got v=%b count=%0d expected v=0 count=0",
                     bus.instr_valid, bus.count);
        end
        assertCount++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
            failCount++;
            $display("FAIL rdw_new_req: got req=%b addr=%h expected req=1 addr=00000100",
                     bus.mem_req, bus.mem_addr);
        end
        step();             // new request waits one cycle
        bus.mem_ack = 1'b1;
        step();             // new request acked
        bus.mem_ack = 1'b0;
        assertCount++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100 ||
            bus.instr !== wordFor(32'h100)) begin
            failCount++;
            $display("FAIL rdw_first_instr: got v=%b pc=%h w=%h expected v=1 pc=00000100 w=%h",
                     bus.instr_valid, bus.instr_pc, bus.instr, wordFor(32'h100));
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_redirect_ack();
        doReset();
        bus.mem_ack     = 1'b1;
        bus.instr_ready = 1'b0;
        step();             // req 0
        step();             // push 0
        step();             // push 4, req 8 on the bus
        assertCount++;
        if (bus.mem_addr !== 32'h8 || bus.count !== 3'd2) begin
            failCount++;
            $display("FAIL rda_setup: got addr=%h count=%0d expected addr=00000008 count=2",
                     bus.mem_addr, bus.count);
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        step();             // ack of 8 coincides with redirect
        bus.redirect    = 1'b0;
        assertCount++;
        if (bus.instr_valid !== 1'b0 || bus.count !== 3'd0) begin
            failCount++;
            $display("FAIL rda_flushed: got v=%b count=%0d expected v=0 count=0",
                     bus.instr_valid, bus.count);
        end
        assertCount++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40) begin
            failCount++;
            $display("FAIL rda_new_req: got req=%b addr=%h expected req=1 addr=00000040",
                     bus.mem_req, bus.mem_addr);
        end
        step();             // push 0x40
        assertCount++;
        if (bus.count !== 3'd1 || bus.instr_pc !== 32'h40) begin
            failCount++;
            $display("FAIL rda_first_instr: got count=%0d pc=%h expected count=1 pc=00000040",
                     bus.count, bus.instr_pc);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        doReset();
        bus.mem_ack     = 1'b1;
        bus.instr_ready = 1'b0;
        step();             // req 0
        step();             // push 0
        step();             // push 4
        step();             // push 8, req 12 pending
        bus.mem_ack = 1'b0;
        assertCount++;
        if (bus.count !== 3'd3 || bus.mem_req !== 1'b1) begin
            failCount++;
            $display("FAIL rmid_setup: got count=%0d req=%b expected count=3 req=1",
                     bus.count, bus.mem_req);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        assertCount++;
        if (bus.mem_req !== 1'b0 || bus.count !== 3'd0 || bus.instr_valid !== 1'b0) begin
            failCount++;
            $display("FAIL rmid_cleared: got req=%b count=%0d v=%b expected req=0 count=0 v=0",
                     bus.mem_req, bus.count, bus.instr_valid);
        end
        bus.mem_ack = 1'b1;
        step();
        assertCount++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
            failCount++;
            $display("FAIL rmid_restart: got req=%b addr=%h expected req=1 addr=00000000",
                     bus.mem_req, bus.mem_addr);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_pc_wrap();
        doReset();
        bus.mem_ack     = 1'b1;
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();             // redirect while idle: stays idle
        bus.redirect    = 1'b0;
        assertCount++;
        if (bus.mem_req !== 1'b0) begin
            failCount++;
            $display("FAIL wrap_idle_redirect: got req=%b expected 0", bus.mem_req);
        end
        step();
        assertCount++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'hFFFF_FFFC) begin
            failCount++;
            $display("FAIL wrap_top_req: got req=%b addr=%h expected req=1 addr=fffffffc",
                     bus.mem_req, bus.mem_addr);
        end
        step();             // 0xFFFFFFFC acked
        assertCount++;
        if (bus.mem_addr !== 32'h0) begin
            failCount++;
            $display("FAIL wrap_next_addr: got %h expected 00000000", bus.mem_addr);
        end
        assertCount++;
        if (bus.instr_pc !== 32'hFFFF_FFFC || bus.instr !== wordFor(32'hFFFF_FFFC)) begin
            failCount++;
            $display("FAIL wrap_head: got pc=%h w=%h expected pc=fffffffc w=%h",
                     bus.instr_pc, bus.instr, wordFor(32'hFFFF_FFFC));
        end
        step();
        assertCount++;
        if (bus.instr_pc !== 32'h0 || bus.count !== 3'd1) begin
            failCount++;
            $display("FAIL wrap_after: got pc=%h count=%0d expected pc=00000000 count=1",
                     bus.instr_pc, bus.count);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        assertCount     = 0;
        failCount       = 0;
        reset           = 1'b1;
        bus.mem_ack     = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;

        test_reset();
        test_stream();
        test_fill();
        test_redirect_wait();
        test_redirect_ack();
        test_reset_mid();
        test_pc_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front-end that sits directly upstream of the single-cycle core. It replaces the core's direct PC-to-instruction-memory path.
- Generates word addresses and issues them to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small FIFO and presents them to the core over a valid/ready interface.
- A branch/jump redirect from the core flushes the queue and restarts fetch at the target, discarding any stale in-flight response.

Parameters:
- DEPTH, 4, number of queue entries (power of two, at least 2)
- RESET_PC, 32'h00000000, first fetch address after reset
- PC_STEP, 4, byte increment between sequential fetches

Ports:
- clock  input  1  single system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock
- mem_req  output  1  request to instruction memory; registered
- mem_addr  output  32  request address; equals fetch_pc; stable while mem_req=1
- mem_ack  input  1  memory accepts the request and returns mem_rdata in the same cycle
- mem_rdata  input  32  instruction word; valid only when mem_req&&mem_ack
- instr_valid  output  1  queue head valid (count!=0)
- instr  output  32  queue head instruction word
- instr_pc  output  32  PC of the queue head
- instr_ready  input  1  core consumes the head this cycle
- redirect  input  1  flush and restart at redirect_pc
- redirect_pc  input  32  new fetch address; word aligned
- count  output  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (synchronous, highest priority):
  - fetch_pc=RESET_PC, count=0, read/write pointers=0, state=IDLE.
  - mem_req=0, instr_valid=0.
  - Reset asserted mid-transaction drops mem_req on the next edge; the memory must abandon the request.
- States:
  - IDLE: mem_req=0. Go to REQ next cycle when count_next<DEPTH and redirect=0.
  - REQ: mem_req=1, mem_addr=fetch_pc. Hold until mem_ack.
    - ack, no redirect: push {fetch_pc, mem_rdata} and set fetch_pc+=PC_STEP. Stay in REQ (back-to-back, new address next cycle) if count_next<DEPTH, else go to IDLE.
    - redirect without ack: fetch_pc=redirect_pc, go to DISCARD.
    - redirect with ack in the same cycle: data dropped, fetch_pc=redirect_pc, stay in REQ at the new address.
  - DISCARD: mem_req stays 1 with the old address; a request is never withdrawn before ack.
    - On ack, data is dropped and the state goes to REQ (if count_next<DEPTH) or IDLE.
    - A further redirect in DISCARD overwrites fetch_pc and stays in DISCARD.
- Queue:
  - Pop when instr_valid&&instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - A request is issued only when count<DEPTH, and only one is ever outstanding, so a push never overflows.
  - instr/instr_pc are read combinationally from registered storage at the read pointer. Their values are don't-care when instr_valid=0.
- Redirect:
  - Flushes on the same edge: count=0, pointers=0; instr_valid=0 on the next cycle.
  - A pop in the redirect cycle is still a legal consumption by the core.
- Latency and throughput:
  - First mem_req is 1 cycle after reset deasserts.
  - With a zero-wait memory (ack tied high) and ready high: one instruction per cycle. A pushed word is visible at the head on the cycle after its ack.
- Arithmetic: fetch_pc wraps modulo 2^32 (32'hFFFFFFFC+4 → 0). No alignment checking.

Test Plan:
- Reset release with ack=1 tied and ready=1 → mem_req=1 at cycle 1 with addr 0; instr_pc 0,4,8,12 on consecutive cycles from cycle 2; count stays at or below 1.
- ready=0 with zero-wait memory → 4 pushes (PCs 0..12), count=4, mem_req=0, IDLE; then ready=1 for one cycle → count=3 and a new req at addr 16.
- Memory with 2-cycle ack latency; redirect to 32'h100 on the first wait cycle → the old word arriving on ack is not queued; next req addr is 32'h100; first instr_pc=32'h100.
- Redirect to 32'h40 in the same cycle as an ack for addr 8 → word 8 is dropped; queue is empty next cycle; mem_req stays high with addr 32'h40.
- Queue holds 3 entries and a request is pending; assert reset for 1 cycle → next cycle mem_req=0, count=0, instr_valid=0; after release the first req is at RESET_PC.
- fetch_pc=32'hFFFFFFFC, acked → next mem_addr=0.
